// File: rtl/mac_sat_pipe.sv
// Pipelined signed multiply-accumulate with saturating accumulator and sticky overflow.
// Stage 1 registers the full-width product; stage 2 accumulates, clamps and flags.
module mac_sat_pipe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic                        clear,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] f,
    output logic                        valid_out,
    output logic                        overflow
);

    localparam int PW  = 2 * WIDTH;
    localparam int EXT = ACC_WIDTH + 1 - PW;

    generate
        if (WIDTH < 2) begin : g_width_chk
            $error("mac_sat_pipe: WIDTH must be >= 2");
        end
        if (ACC_WIDTH < 2 * WIDTH) begin : g_acc_chk
            $error("mac_sat_pipe: ACC_WIDTH must be >= 2*WIDTH");
        end
    endgenerate

    logic signed [PW-1:0]        a_x;
    logic signed [PW-1:0]        b_x;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_q;
    logic                        v_q;
    logic                        clr_q;

    logic signed [ACC_WIDTH-1:0] base;
    logic        [ACC_WIDTH:0]   sum;
    logic                        sat;
    logic signed [ACC_WIDTH-1:0] f_next;
    logic                        ovf_next;

    // Operands are sign-extended first so the product is computed at full width.
    assign a_x  = PW'(a);
    assign b_x  = PW'(b);
    assign prod = a_x * b_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            v_q    <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            if (valid_in) begin
                prod_q <= prod;
            end
            v_q   <= valid_in;
            clr_q <= clear;
        end
    end

    always_comb begin
        base = clr_q ? '0 : f;
        sum  = {base[ACC_WIDTH-1], base} + {{EXT{prod_q[PW-1]}}, prod_q};
        // One guard bit: overflow iff the top two bits of the sum disagree.
        sat  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

        f_next = base;
        if (v_q) begin
            if (sat) begin
                f_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                f_next = sum[ACC_WIDTH-1:0];
            end
        end

        ovf_next = (~clr_q & overflow) | (v_q & sat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f         <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            f         <= f_next;
            valid_out <= v_q | clr_q;
            overflow  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mac_sat_pipe.sv
// Directed-vector and random-model bench for mac_sat_pipe in two width configurations.
module tb_mac_sat_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst8, v8, c8;
    logic signed [7:0]  a8, b8;
    logic signed [15:0] f8;
    logic               vo8, ov8;

    logic               rst4, v4, c4;
    logic signed [3:0]  a4, b4;
    logic signed [7:0]  f4;
    logic               vo4, ov4;

    mac_sat_pipe #(.WIDTH(8), .ACC_WIDTH(16)) dut8 (
        .clk(clk), .reset(rst8), .valid_in(v8), .clear(c8), .a(a8), .b(b8),
        .f(f8), .valid_out(vo8), .overflow(ov8)
    );

    mac_sat_pipe #(.WIDTH(4), .ACC_WIDTH(8)) dut4 (
        .clk(clk), .reset(rst4), .valid_in(v4), .clear(c4), .a(a4), .b(b4),
        .f(f4), .valid_out(vo4), .overflow(ov4)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Expected values in each row describe the outputs after that row's clock edge.
    typedef struct {
        bit rst; bit vld; bit clr;
        int a;   int b;
        int ef;  bit evo; bit eovf;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    typedef struct {
        longint p; bit v; bit c;
        longint f; bit vo; bit ov;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t s, input int accw, input bit rst,
                                      input bit vld, input bit clr, input longint x, input longint y);
        mstate_t n;
        longint  mx, mn, acc, sm;
        bit      sat;
        n  = s;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -(longint'(1) <<< (accw - 1));
        if (rst) begin
            n = '{0, 0, 0, 0, 0, 0};
        end else begin
            acc = s.c ? 0 : s.f;
            sat = 0;
            if (s.v) begin
                sm = acc + s.p;
                if (sm > mx)      begin sm = mx; sat = 1; end
                else if (sm < mn) begin sm = mn; sat = 1; end
                n.f = sm;
            end else begin
                n.f = acc;
            end
            n.ov = (s.c ? 1'b0 : s.ov) | sat;
            n.vo = s.v | s.c;
            if (vld) n.p = x * y;
            n.v = vld;
            n.c = clr;
        end
        return n;
    endfunction

    task automatic step4(input bit r, input bit v, input bit c, input int x, input int y,
                         input int ef, input bit evo, input bit eov, input string nm);
        rst4 = r; v4 = v; c4 = c; a4 = 4'(x); b4 = 4'(y);
        @(posedge clk); #1;
        chk({nm, " f"}, longint'(f4), ef);
        chk({nm, " valid_out"}, longint'(vo4), evo);
        chk({nm, " overflow"}, longint'(ov4), eov);
    endtask

    initial begin
        mstate_t m8, m4;

        tbl[0]  = '{1,0,0,    0,    0,      0,0,0};
        tbl[1]  = '{0,1,0,    3,    4,      0,0,0};
        tbl[2]  = '{0,1,0,   -2,    5,     12,1,0};
        tbl[3]  = '{0,1,0,    7,   -1,      2,1,0};
        tbl[4]  = '{0,0,0,    0,    0,     -5,1,0};
        tbl[5]  = '{0,0,0,    0,    0,     -5,0,0};
        tbl[6]  = '{0,1,1,  127,  127,     -5,0,0};
        tbl[7]  = '{0,1,0,  127,  127,  16129,1,0};
        tbl[8]  = '{0,1,0,  127,  127,  32258,1,0};
        tbl[9]  = '{0,1,0,   -1,    1,  32767,1,1};
        tbl[10] = '{0,0,0,    0,    0,  32766,1,1};
        tbl[11] = '{0,0,0,    0,    0,  32766,0,1};
        tbl[12] = '{0,1,1, -128, -128,  32766,0,1};
        tbl[13] = '{0,1,1, -128,  127,  16384,1,0};
        tbl[14] = '{0,1,0, -128,  127, -16256,1,0};
        tbl[15] = '{0,1,0, -128,  127, -32512,1,0};
        tbl[16] = '{0,0,0,    0,    0, -32768,1,1};
        tbl[17] = '{0,0,0,    0,    0, -32768,0,1};
        tbl[18] = '{0,1,1,   10,   10, -32768,0,1};
        tbl[19] = '{0,0,0,    0,    0,    100,1,0};
        tbl[20] = '{0,0,1,    0,    0,    100,0,0};
        tbl[21] = '{0,0,0,    0,    0,      0,1,0};
        tbl[22] = '{0,1,0,    5,   10,      0,0,0};
        tbl[23] = '{0,0,0,    0,    0,     50,1,0};
        tbl[24] = '{0,1,1,   10,   10,     50,0,0};
        tbl[25] = '{0,0,0,    0,    0,    100,1,0};
        tbl[26] = '{0,1,1,    5,    5,    100,0,0};
        tbl[27] = '{0,0,0,    0,    0,     25,1,0};
        tbl[28] = '{0,0,0,    0,    0,     25,0,0};
        tbl[29] = '{0,0,0,    0,    0,     25,0,0};
        tbl[30] = '{0,1,0,    2,    2,     25,0,0};
        tbl[31] = '{0,0,0,    0,    0,     29,1,0};
        tbl[32] = '{0,1,0,    9,    9,     29,0,0};
        tbl[33] = '{1,0,0,    0,    0,      0,0,0};
        tbl[34] = '{0,0,0,    0,    0,      0,0,0};

        rst4 = 1; v4 = 0; c4 = 0; a4 = '0; b4 = '0;
        rst8 = 1; v8 = 0; c8 = 0; a8 = '0; b8 = '0;
        #2;

        for (int i = 0; i < NV; i++) begin
            rst8 = tbl[i].rst; v8 = tbl[i].vld; c8 = tbl[i].clr;
            a8 = 8'(tbl[i].a); b8 = 8'(tbl[i].b);
            @(posedge clk); #1;
            chk($sformatf("vec%0d f", i), longint'(f8), tbl[i].ef);
            chk($sformatf("vec%0d valid_out", i), longint'(vo8), tbl[i].evo);
            chk($sformatf("vec%0d overflow", i), longint'(ov8), tbl[i].eovf);
        end

        step4(1, 0, 0,  0, 0,   0, 0, 0, "w4 reset");
        step4(0, 1, 0,  7, 7,   0, 0, 0, "w4 p1");
        step4(0, 1, 0,  7, 7,  49, 1, 0, "w4 p2");
        step4(0, 1, 0,  7, 7,  98, 1, 0, "w4 p3");
        step4(0, 1, 0, -8, 7, 127, 1, 1, "w4 sat");
        step4(0, 0, 0,  0, 0,  71, 1, 1, "w4 dec");
        step4(0, 0, 1,  0, 0,  71, 0, 1, "w4 gap");
        step4(0, 0, 0,  0, 0,   0, 1, 0, "w4 clr");

        m8 = '{0, 0, 0, 0, 0, 0};
        m4 = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 1000; i++) begin
            rst8 = (i == 0) || ($urandom_range(63) == 0);
            v8   = ($urandom_range(3) != 0);
            c8   = ($urandom_range(7) == 0);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            rst4 = (i == 0) || ($urandom_range(63) == 0);
            v4   = ($urandom_range(3) != 0);
            c4   = ($urandom_range(7) == 0);
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            m8 = mstep(m8, 16, rst8, v8, c8, longint'(a8), longint'(b8));
            m4 = mstep(m4, 8,  rst4, v4, c4, longint'(a4), longint'(b4));
            @(posedge clk); #1;
            chk($sformatf("rnd8[%0d] f", i), longint'(f8), m8.f);
            chk($sformatf("rnd8[%0d] valid_out", i), longint'(vo8), longint'(m8.vo));
            chk($sformatf("rnd8[%0d] overflow", i), longint'(ov8), longint'(m8.ov));
            chk($sformatf("rnd4[%0d] f", i), longint'(f4), m4.f);
            chk($sformatf("rnd4[%0d] valid_out", i), longint'(vo4), longint'(m4.vo));
            chk($sformatf("rnd4[%0d] overflow", i), longint'(ov4), longint'(m4.ov));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
